// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arbiter round-robin memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // Read data returned to a master whose transaction was abandoned by the watchdog.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; grants the first requester strictly after 'last'.
module rr_pick #(
    parameter int N    = 2,
    parameter int IDXW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last,
    output logic [N-1:0]    pick,
    output logic [IDXW-1:0] pick_idx,
    output logic            any
);

    localparam int CW = IDXW + 1;

    logic [CW-1:0] cand_s;
    logic          found_s;

    // Walk candidates last+1 .. last+N modulo N and take the first one requesting.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int off = 1; off <= N; off++) begin
            cand_s = {1'b0, last} + CW'(off);
            if (cand_s >= CW'(N)) begin
                cand_s = cand_s - CW'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDXW-1:0]]) begin
                found_s                = 1'b1;
                pick[cand_s[IDXW-1:0]] = 1'b1;
                pick_idx               = cand_s[IDXW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-master round-robin arbiter in front of the single io_ctrl memory port.
// Optional bus watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_data,
    output logic [DATA_WIDTH-1:0]             m_read_data,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_write_data,
    input  logic [DATA_WIDTH-1:0]             mem_read_data,
    input  logic                              mem_ack,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy,
    output logic                              err
);

    localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_WORD = DATA_WIDTH'(TIMEOUT_DATA);

    arb_state_e state_r, state_n;

    logic [NUM_MASTERS-1:0] req_s, pick_s;
    logic [IDXW-1:0]        pick_idx_s;
    logic                   any_s;
    logic                   timeout_s;
    logic [ADDR_WIDTH-1:0]  addr_sel_s;
    logic [DATA_WIDTH-1:0]  wdata_sel_s;

    logic [NUM_MASTERS-1:0] grant_r, grant_n, m_ack_r, m_ack_n;
    logic                   mem_read_r, mem_read_n, mem_write_r, mem_write_n;
    logic                   op_write_r, op_write_n, busy_r, busy_n;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_n;
    logic [DATA_WIDTH-1:0]  wdata_r, wdata_n, rdata_r, rdata_n;
    logic [IDXW-1:0]        last_r, last_n;

    assign req_s = m_read | m_write;

    rr_pick #(
        .N    (NUM_MASTERS),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req      (req_s),
        .last     (last_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .any      (any_s)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    // A real ack on the expiry cycle wins over the watchdog.
    assign timeout_s = (state_r == ST_BUSY) && !mem_ack &&
                       (cnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter runs only in BUSY; err is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            cnt_r <= (state_r == ST_BUSY) ? (cnt_r + CNT_W'(1)) : '0;
            err_r <= err_r | timeout_s;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // One-hot mux of the winning master's address and write data.
    always_comb begin
        addr_sel_s  = '0;
        wdata_sel_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_sel_s  = addr_sel_s  | ({ADDR_WIDTH{pick_s[i]}} & m_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            wdata_sel_s = wdata_sel_s | ({DATA_WIDTH{pick_s[i]}} & m_write_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // State and registered output/datapath update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            m_ack_r     <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            op_write_r  <= 1'b0;
            busy_r      <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            last_r      <= IDXW'(NUM_MASTERS - 1);
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            m_ack_r     <= m_ack_n;
            mem_read_r  <= mem_read_n;
            mem_write_r <= mem_write_n;
            op_write_r  <= op_write_n;
            busy_r      <= busy_n;
            addr_r      <= addr_n;
            wdata_r     <= wdata_n;
            rdata_r     <= rdata_n;
            last_r      <= last_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_n = ST_BUSY;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack || timeout_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_BUSY;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Next values of the output registers; strobes and acks follow the next state.
    always_comb begin
        grant_n     = grant_r;
        m_ack_n     = '0;
        mem_read_n  = 1'b0;
        mem_write_n = 1'b0;
        op_write_n  = op_write_r;
        addr_n      = addr_r;
        wdata_n     = wdata_r;
        rdata_n     = rdata_r;
        last_n      = last_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    grant_n     = pick_s;
                    last_n      = pick_idx_s;
                    op_write_n  = |(m_write & pick_s);
                    mem_write_n = op_write_n;
                    mem_read_n  = ~op_write_n;
                    addr_n      = addr_sel_s;
                    wdata_n     = wdata_sel_s;
                end else begin
                    grant_n = '0;
                end
            end
            ST_BUSY: begin
                if (mem_ack || timeout_s) begin
                    m_ack_n = grant_r;
                    if (!op_write_r) begin
                        rdata_n = mem_ack ? mem_read_data : TIMEOUT_WORD;
                    end else begin
                        rdata_n = rdata_r;
                    end
                end else begin
                    mem_read_n  = ~op_write_r;
                    mem_write_n = op_write_r;
                end
            end
            ST_DONE: grant_n = '0;
            default: grant_n = '0;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    assign grant          = grant_r;
    assign m_ack          = m_ack_r;
    assign mem_read       = mem_read_r;
    assign mem_write      = mem_write_r;
    assign mem_addr       = addr_r;
    assign mem_write_data = wdata_r;
    assign m_read_data    = rdata_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter; covers the watchdog when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 2*NM + 3 + AW + DW;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NM-1:0]    m_read, m_write, m_ack, grant;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_write_data;
    logic [DW-1:0]    m_read_data, mem_write_data, mem_read_data;
    logic [AW-1:0]    mem_addr;
    logic             mem_read, mem_write, mem_ack, busy, err;

    int            checks = 0;
    int            failures = 0;
    int            model_last;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;

    mem_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_addr         (m_addr),
        .m_write_data   (m_write_data),
        .m_read_data    (m_read_data),
        .m_ack          (m_ack),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ack        (mem_ack),
        .grant          (grant),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Reference: winner is first requester after the previous winner, wrapping.
    function automatic int rr_winner(input logic [NM-1:0] req, input int last);
        int w = -1;
        for (int i = 1; i <= NM; i++) begin
            if (w < 0 && req[(last + i) % NM]) w = (last + i) % NM;
        end
        return w;
    endfunction

    // One transaction starting from an IDLE cycle with requests already driven.
    task automatic serve(input int delay, input bit move_addr, input logic [DW-1:0] rdv);
        int            w;
        bit            wr;
        logic [NM-1:0] oh;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [TW-1:0] act, exp;
        w = rr_winner(m_read | m_write, model_last);
        if (w < 0) return;
        wr = m_write[w];
        oh = '0;
        oh[w] = 1'b1;
        ea = m_addr[w*AW +: AW];
        ed = m_write_data[w*DW +: DW];
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            act = {mem_read, mem_write, grant, busy, m_ack, mem_addr, mem_write_data};
            exp = {~wr, wr, oh, 1'b1, {NM{1'b0}}, ea, ed};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL busy_cycle%0d master=%0d got=%h want=%h", c, w, act, exp);
            end
            if (move_addr) m_addr[w*AW +: AW] = $urandom;
        end
        mem_ack = 1'b1;
        mem_read_data = rdv;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_read_data = $urandom;
        if (!wr) exp_rdata = rdv;
        model_last = w;
        checks++;
        if ({mem_read, mem_write, grant, busy, m_ack, m_read_data, err} !==
            {1'b0, 1'b0, oh, 1'b1, oh, exp_rdata, exp_err}) begin
            failures++;
            $display("FAIL done_cycle master=%0d got ack=%b grant=%b rd=%h busy=%b strobes=%b%b err=%b want ack=%b rd=%h err=%b",
                     w, m_ack, grant, m_read_data, busy, mem_read, mem_write, err, oh, exp_rdata, exp_err);
        end
        @(negedge clk);
        checks++;
        if ({grant, m_ack, busy, mem_read, mem_write} !== '0) begin
            failures++;
            $display("FAIL idle_after master=%0d got grant=%b ack=%b busy=%b strobes=%b%b want all 0",
                     w, grant, m_ack, busy, mem_read, mem_write);
        end
    endtask

    task automatic model_reset();
        model_last = NM - 1;
        exp_rdata  = '0;
        exp_err    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_read = 2'b01; m_write = '0; mem_ack = 1'b0; mem_read_data = '0;
        m_addr = {32'h0000_0200, 32'h0000_0100};
        m_write_data = {32'h2222_2222, 32'h1111_1111};
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, m_ack, busy, mem_read, mem_write, err, m_read_data} !== '0) begin
            failures++;
            $display("FAIL reset_state got grant=%b ack=%b busy=%b strobes=%b%b err=%b rd=%h want 0",
                     grant, m_ack, busy, mem_read, mem_write, err, m_read_data);
        end
        reset_n = 1'b1;
        serve(0, 1'b0, 32'h1234_5678);
        m_read = '0;
    endtask

    task automatic test_back_to_back();
        m_read = '1; m_write = '0;
        for (int t = 0; t < 4; t++) serve(0, 1'b0, $urandom);
        m_read = '0;
    endtask

    task automatic test_write();
        m_read = '0; m_write = 2'b10;
        m_addr[1*AW +: AW] = 32'h0000_0010;
        m_write_data[1*DW +: DW] = 32'hCAFE_0001;
        serve(1, 1'b0, $urandom);
        m_read = 2'b01; m_write = 2'b01;
        serve(0, 1'b0, $urandom);
        m_read = '0; m_write = '0;
    endtask

    task automatic test_delay();
        m_read = 2'b01; m_write = '0;
        m_addr[0 +: AW] = 32'h0000_0ABC;
`ifdef MEM_ARB_TIMEOUT_EN
        serve(2, 1'b1, $urandom);
`else
        serve(5, 1'b1, $urandom);
`endif
        m_read = '0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            m_read  = NM'($urandom);
            m_write = NM'($urandom);
            if ((m_read | m_write) == '0) m_read[$urandom_range(0, NM-1)] = 1'b1;
            for (int i = 0; i < NM; i++) begin
                m_addr[i*AW +: AW]       = $urandom;
                m_write_data[i*DW +: DW] = $urandom;
            end
            serve(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), $urandom);
        end
        m_read = '0; m_write = '0;
    endtask

    task automatic test_reset_mid_busy();
        m_read = 2'b10; m_write = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup got mem_read=%b want 1", mem_read);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, grant, busy, m_ack} !== '0) begin
            failures++;
            $display("FAIL async_abort got strobes=%b%b grant=%b busy=%b ack=%b want 0",
                     mem_read, mem_write, grant, busy, m_ack);
        end
        m_read = '1;
        @(negedge clk);
        checks++;
        if ({m_ack, busy} !== '0) begin
            failures++;
            $display("FAIL abort_no_ack got ack=%b busy=%b want 0", m_ack, busy);
        end
        reset_n = 1'b1;
        model_reset();
        serve(0, 1'b0, $urandom);
        m_read = '0;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m_read = 2'b01; m_write = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_read, m_ack} !== {1'b1, {NM{1'b0}}}) begin
                failures++;
                $display("FAIL wd_busy%0d got mem_read=%b ack=%b want 1/0", c, mem_read, m_ack);
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_read, m_ack, m_read_data, err} !== {1'b0, 2'b01, 32'hDEADBEEF, 1'b1}) begin
            failures++;
            $display("FAIL wd_expire got mem_read=%b ack=%b rd=%h err=%b want 0/01/deadbeef/1",
                     mem_read, m_ack, m_read_data, err);
        end
        m_read = '0;
        model_last = 0;
        exp_rdata  = 32'hDEADBEEF;
        exp_err    = 1'b1;
        @(negedge clk);
        m_read = 2'b10;
        serve(0, 1'b0, $urandom);
        m_read = '0;
    endtask
`endif

    task automatic test_final_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({err, m_read_data, grant, busy} !== '0) begin
            failures++;
            $display("FAIL final_reset got err=%b rd=%h grant=%b busy=%b want 0",
                     err, m_read_data, grant, busy);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_write();
        test_delay();
        test_random();
        test_reset_mid_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_final_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-master round-robin arbiter for the ACE memory bus, placed between bus masters (CPU core, debug/DMA ports) and the single `io_ctrl` memory port. Each master keeps the existing `mem_read`/`mem_write`/`mem_ack` level-request/pulse-ack protocol unchanged. Adds fair arbitration, a grant indicator for board LEDs, and an optional bus watchdog.

## Interface
- `NUM_MASTERS`, 2, number of master channels (2..8)
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `TIMEOUT_CYCLES`, 255, watchdog limit in BUSY cycles (only with `MEM_ARB_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `m_read` in NUM_MASTERS: per-master read request, level
- `m_write` in NUM_MASTERS: per-master write request, level
- `m_addr` in NUM_MASTERS*ADDR_WIDTH: flattened, master i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `m_write_data` in NUM_MASTERS*DATA_WIDTH: flattened, same packing
- `m_read_data` out DATA_WIDTH: shared read-data return, valid when the master's `m_ack` bit is high
- `m_ack` out NUM_MASTERS: one-cycle ack pulse per master
- `mem_read`, `mem_write` out 1: strobes to `io_ctrl`
- `mem_addr` out ADDR_WIDTH, `mem_write_data` out DATA_WIDTH: to `io_ctrl`
- `mem_read_data` in DATA_WIDTH, `mem_ack` in 1: from `io_ctrl`
- `grant` out NUM_MASTERS: one-hot owner, zero when idle
- `busy` out 1: high in BUSY and DONE
- `err` out 1: sticky watchdog flag

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: request vector is `m_read | m_write`. If it is nonzero, pick the first requester strictly after `last` (wrapping), then:
  - register `grant`, `mem_addr`, `mem_write_data` and the op;
  - update `last`;
  - go to BUSY.
- Op rules: read and write both high on a master means write; read is ignored.
- BUSY: drive `mem_read` or `mem_write` from registered state. When `mem_ack` is high:
  - latch `mem_read_data` (reads only);
  - drop the strobe;
  - go to DONE.
- DONE: `m_ack[grant]` = 1 and `m_read_data` = latched data for exactly one cycle, then IDLE with `grant` cleared.
- Masters must deassert their request in the cycle after `m_ack`.
- Requests that change during BUSY are ignored. Address and data are captured once, at grant.
- Every transaction has at least one IDLE cycle after it. `io_ctrl` must drop `mem_ack` within one cycle of its strobe falling. `mem_ack` seen in IDLE or DONE is ignored.
- Reset values:
  - all outputs 0; `m_read_data` 0;
  - state IDLE;
  - `last` = NUM_MASTERS-1, so master 0 wins first.
- Reset mid-transaction aborts immediately: strobes drop asynchronously and no ack is issued.

## Timing
- Request seen at edge k → strobe high from k+1.
- `mem_ack` seen at edge j → strobe low and `m_ack` high from j+1 → IDLE at j+2.
- Minimum transaction is 3 cycles request-to-ack (slave acks in its first strobe cycle). Back-to-back issue is every 3 cycles.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transactions.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - an 8..16-bit counter clears on BUSY entry and increments each BUSY cycle;
  - on reaching TIMEOUT_CYCLES without `mem_ack`: strobe dropped, go to DONE, `m_read_data` = `TIMEOUT_DATA` (reads), `err` set.
  - `err` clears only on reset.
- Undefined: no counter; `err` tied 0; BUSY waits indefinitely.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, BUSY, DONE) and the `TIMEOUT_DATA` constant (`32'hDEADBEEF`, truncated to DATA_WIDTH).
- Sub-module `rr_pick`: combinational round-robin picker, parametrised by N.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `pick`, index `pick_idx`, `any`.

## Test plan
- Reset with `m_read[0]`=1 held: after release, `grant`=01 one cycle later, `mem_addr` = master 0 address, `m_ack[0]` pulses once, `m_read_data` = slave data (e.g. 32'h1234_5678).
- Both masters requesting continuously, slave acks in 1 cycle: grants alternate 0,1,0,1. Each `m_ack` is exactly 1 cycle. Transactions are spaced by 3 cycles.
- Master 1 writes 32'hCAFE_0001 to 32'h10: `mem_write`=1 with that addr/data until ack. `m_read_data` unchanged. A master asserting read and write together produces a write.
- Slave delays ack 5 cycles while master 0 changes `m_addr`: `mem_addr` stays at the grant-time value. `m_ack[0]` arrives 1 cycle after `mem_ack`.
- `reset_n` pulsed low in BUSY: strobes go 0 without waiting for a clock, no `m_ack`. After release, master 0 wins first.
- With `MEM_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=4, slave never acks: strobe drops after 4 BUSY cycles, `m_ack` pulses with data 32'hDEADBEEF, `err`=1 until reset.
